// File: rtl/square_wave_sequencer_if.sv
// Control/table/feedback bundle between a controller and square_wave_sequencer.
// master drives writes, start/stop and wave feedback; slave returns the applied m/n and status.
interface square_wave_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  parameter int RPT_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_m;
  logic [W-1:0]     wr_n;
  logic [RPT_W-1:0] wr_rpt;
  logic [AW-1:0]    last_idx;
  logic             loop_en;
  logic             start;
  logic             stop;
  logic             wave_in;
  logic [W-1:0]     m_out;
  logic [W-1:0]     n_out;
  logic [AW-1:0]    cur_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output wr_en, wr_addr, wr_m, wr_n, wr_rpt, last_idx, loop_en, start, stop, wave_in,
    input  m_out, n_out, cur_idx, busy, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_m, wr_n, wr_rpt, last_idx, loop_en, start, stop, wave_in,
    output m_out, n_out, cur_idx, busy, done, err
  );
endinterface

// File: rtl/square_wave_sequencer.sv
// Steps squareWaveGen m/n through a table, switching only on wave_in rising edges.
// Latency: outputs follow a detected rise by one clock; no backpressure, start/stop while not acceptable are dropped.
module square_wave_sequencer #(
  parameter int DEPTH   = 8,
  parameter int W       = 4,
  parameter int RPT_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input logic                    clk,
  input logic                    reset,
  square_wave_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  typedef struct packed {
    logic [W-1:0]     m;
    logic [W-1:0]     n;
    logic [RPT_W-1:0] rpt;
  } entry_t;

  entry_t           tbl [DEPTH];
  state_t           state;
  logic             wave_q;
  logic             stop_pend;
  logic [AW-1:0]    last_q;
  logic             loop_q;
  logic [RPT_W-1:0] cnt;
  logic [TW-1:0]    timer;

  logic [W-1:0]     m_q;
  logic [W-1:0]     n_q;
  logic [AW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             rise;
  entry_t           wr_e;
  entry_t           first_e;
  entry_t           nxt_e;
  logic [AW-1:0]    nxt_idx;
  logic [RPT_W-1:0] rpt_eff;
  logic             at_last;
  logic             exit_done;
  logic             exit_err;

  assign rise = bus.wave_in & ~wave_q;

  always_comb begin
    wr_e    = '{m: bus.wr_m, n: bus.wr_n, rpt: bus.wr_rpt};
    // A write landing on entry 0 together with start must be seen by that start.
    first_e = (bus.wr_en && bus.wr_addr == '0) ? wr_e : tbl[0];
    rpt_eff = (tbl[idx_q].rpt == '0) ? RPT_W'(1) : tbl[idx_q].rpt;
    at_last = (idx_q == last_q);
    nxt_idx = at_last ? '0 : idx_q + AW'(1);
    nxt_e   = tbl[nxt_idx];

    exit_done = 1'b0;
    if (state == SYNC && stop_pend)
      exit_done = 1'b1;
    if (state == RUN && rise &&
        (stop_pend || bus.stop || (cnt >= rpt_eff && at_last && !loop_q)))
      exit_done = 1'b1;

    exit_err = (state != IDLE) && !exit_done && !rise && (timer == TMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      state     <= IDLE;
      wave_q    <= 1'b0;
      stop_pend <= 1'b0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      cnt       <= '0;
      timer     <= '0;
      m_q       <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wave_q <= bus.wave_in;
      done_q <= 1'b0;
      if (state != IDLE && bus.stop) stop_pend <= 1'b1;

      if (exit_done || exit_err) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        m_q       <= '0;
        n_q       <= '0;
        idx_q     <= '0;
        stop_pend <= 1'b0;
        done_q    <= exit_done;
        if (exit_err) err_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.wr_en) tbl[bus.wr_addr] <= wr_e;
            if (bus.start && !bus.stop) begin
              state     <= SYNC;
              busy_q    <= 1'b1;
              m_q       <= first_e.m;
              n_q       <= first_e.n;
              idx_q     <= '0;
              err_q     <= 1'b0;
              last_q    <= bus.last_idx;
              loop_q    <= bus.loop_en;
              timer     <= '0;
              stop_pend <= 1'b0;
            end
          end
          SYNC: begin
            if (rise) begin
              state <= RUN;
              cnt   <= RPT_W'(1);
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          RUN: begin
            if (rise) begin
              timer <= '0;
              // The edge that advances also counts as period 1 of the new entry.
              if (cnt >= rpt_eff) begin
                idx_q <= nxt_idx;
                m_q   <= nxt_e.m;
                n_q   <= nxt_e.n;
                cnt   <= RPT_W'(1);
              end else begin
                cnt <= cnt + RPT_W'(1);
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.m_out   = m_q;
  assign bus.n_out   = n_q;
  assign bus.cur_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_square_wave_sequencer.sv
// Directed bench for square_wave_sequencer: period-schedule model checked every cycle plus literal spot checks.
module tb_square_wave_sequencer;
  localparam int DEPTH   = 8;
  localparam int W       = 4;
  localparam int RPT_W   = 8;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  square_wave_sequencer_if #(.DEPTH(DEPTH), .W(W), .RPT_W(RPT_W)) bus ();

  square_wave_sequencer #(.DEPTH(DEPTH), .W(W), .RPT_W(RPT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is the expanded list of entry indices, one per wave period.
  int  mm [DEPTH];
  int  mn [DEPTH];
  int  mr [DEPTH];
  int  pat[$];
  int  ph;
  int  r;
  int  timer;
  bit  stop_p, loop_m, m_err, m_done, m_prev, mvalid;

  always @(posedge clk) begin
    bit rise;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin mm[i] = 0; mn[i] = 0; mr[i] = 0; end
      ph = 0; r = 0; timer = 0; stop_p = 0; loop_m = 0;
      m_err = 0; m_done = 0; m_prev = 0; mvalid = 1;
    end else begin
      rise   = bus.wave_in && !m_prev;
      m_prev = bus.wave_in;
      m_done = 0;
      if (ph == 0) begin
        if (bus.wr_en) begin
          mm[bus.wr_addr] = bus.wr_m; mn[bus.wr_addr] = bus.wr_n; mr[bus.wr_addr] = bus.wr_rpt;
        end
        if (bus.start && !bus.stop) begin
          pat.delete();
          for (int e = 0; e <= int'(bus.last_idx); e++)
            for (int k = 0; k < ((mr[e] == 0) ? 1 : mr[e]); k++) pat.push_back(e);
          loop_m = bus.loop_en; ph = 1; timer = 0; m_err = 0; stop_p = 0;
        end
      end else begin
        if (ph == 1 && stop_p) begin
          ph = 0; m_done = 1;
        end else if (rise) begin
          timer = 0;
          if (ph == 1) begin
            ph = 2; r = 1;
          end else if (stop_p || bus.stop) begin
            ph = 0; m_done = 1;
          end else begin
            r++;
            if (r > pat.size() && !loop_m) begin ph = 0; m_done = 1; end
          end
        end else if (timer == TIMEOUT - 1) begin
          ph = 0; m_err = 1;
        end else begin
          timer++;
        end
        if (ph != 0 && bus.stop) stop_p = 1;
      end
    end
  end

  always @(negedge clk) begin
    int ei, em, en;
    if (mvalid) begin
      ei = 0; em = 0; en = 0;
      if (ph == 1) begin em = mm[0]; en = mn[0]; end
      if (ph == 2) begin ei = pat[(r - 1) % pat.size()]; em = mm[ei]; en = mn[ei]; end
      chk("model {m,n,idx,busy,done,err}",
          {18'd0, bus.m_out, bus.n_out, bus.cur_idx, bus.busy, bus.done, bus.err},
          {18'd0, 4'(em), 4'(en), 3'(ei), ph != 0, m_done, m_err});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int m, input int n, input int rpt);
    bus.wr_en = 1; bus.wr_addr = 3'(a); bus.wr_m = 4'(m); bus.wr_n = 4'(n); bus.wr_rpt = 8'(rpt);
    cyc(1);
    bus.wr_en = 0;
  endtask

  task automatic go(input int last, input bit lp);
    bus.last_idx = 3'(last); bus.loop_en = lp; bus.start = 1;
    cyc(1);
    bus.start = 0;
  endtask

  task automatic rise_now();
    bus.wave_in = 1;
    cyc(1);
  endtask

  task automatic finish_period();
    cyc(1);
    bus.wave_in = 0;
    cyc(2);
  endtask

  initial begin
    int seq [7];
    seq = '{0, 0, 1, 0, 0, 1, 0};
    reset = 1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_m = 0; bus.wr_n = 0; bus.wr_rpt = 0;
    bus.last_idx = 0; bus.loop_en = 0; bus.start = 0; bus.stop = 0; bus.wave_in = 0;
    cyc(2);
    reset = 0;
    chk("reset busy", bus.busy, 0);
    chk("reset m_out", bus.m_out, 0);
    chk("reset err", bus.err, 0);

    // Two-entry table, one-shot
    wr(0, 3, 2, 2);
    wr(1, 1, 1, 1);
    go(1, 0);
    chk("t1 sync busy", bus.busy, 1);
    chk("t1 sync m", bus.m_out, 3);
    chk("t1 sync n", bus.n_out, 2);
    rise_now(); chk("t1 r1 idx", bus.cur_idx, 0); finish_period();
    rise_now(); chk("t1 r2 m", bus.m_out, 3);     finish_period();
    rise_now(); chk("t1 r3 idx", bus.cur_idx, 1); chk("t1 r3 m", bus.m_out, 1); finish_period();
    rise_now();
    chk("t1 done", bus.done, 1);
    chk("t1 end busy", bus.busy, 0);
    chk("t1 end m", bus.m_out, 0);
    finish_period();
    chk("t1 done drops", bus.done, 0);

    // Looping, then graceful stop in the middle of entry 0
    go(1, 1);
    for (int i = 0; i < 7; i++) begin
      rise_now();
      chk($sformatf("t2 idx[%0d]", i), bus.cur_idx, seq[i]);
      chk($sformatf("t2 busy[%0d]", i), bus.busy, 1);
      if (i < 6) finish_period();
    end
    bus.stop = 1; cyc(1); bus.stop = 0;
    bus.wave_in = 0; cyc(2);
    chk("t2 stop pending busy", bus.busy, 1);
    chk("t2 stop pending done", bus.done, 0);
    rise_now();
    chk("t2 stop done", bus.done, 1);
    chk("t2 stop busy", bus.busy, 0);
    bus.wave_in = 0; cyc(2);

    // Timeout with no feedback, restart clears err, stop in SYNC
    go(0, 0);
    cyc(TIMEOUT - 1);
    chk("t3 pre-timeout err", bus.err, 0);
    chk("t3 pre-timeout busy", bus.busy, 1);
    cyc(1);
    chk("t3 timeout err", bus.err, 1);
    chk("t3 timeout busy", bus.busy, 0);
    chk("t3 timeout done", bus.done, 0);
    go(0, 0);
    chk("t3 restart err", bus.err, 0);
    bus.stop = 1; cyc(1); bus.stop = 0;
    chk("t3 sync stop busy", bus.busy, 1);
    cyc(1);
    chk("t3 sync stop done", bus.done, 1);
    chk("t3 sync stop busy2", bus.busy, 0);

    // rpt=0 entries, plus a write attempted while busy
    wr(0, 5, 6, 0);
    wr(1, 7, 8, 0);
    go(1, 0);
    rise_now(); chk("t4 r1 m", bus.m_out, 5); finish_period();
    rise_now(); chk("t4 r2 idx", bus.cur_idx, 1); chk("t4 r2 n", bus.n_out, 8);
    wr(1, 9, 9, 3);
    bus.wave_in = 0; cyc(2);
    rise_now(); chk("t4 done", bus.done, 1);
    bus.wave_in = 0; cyc(2);

    // Write and start together; busy write must not have landed
    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_m = 2; bus.wr_n = 3; bus.wr_rpt = 1;
    bus.last_idx = 1; bus.loop_en = 0; bus.start = 1;
    cyc(1);
    bus.wr_en = 0; bus.start = 0;
    chk("t5 fwd m", bus.m_out, 2);
    chk("t5 fwd n", bus.n_out, 3);
    rise_now(); finish_period();
    rise_now(); chk("t5 r2 m", bus.m_out, 7); chk("t5 r2 idx", bus.cur_idx, 1); finish_period();
    rise_now(); chk("t5 done", bus.done, 1);
    bus.wave_in = 0; cyc(2);

    // start & stop together
    bus.start = 1; bus.stop = 1; cyc(1); bus.start = 0; bus.stop = 0;
    chk("t6 start+stop busy", bus.busy, 0);
    cyc(2);

    // Reset in RUN clears everything including the table
    go(1, 0);
    rise_now();
    chk("t7 run busy", bus.busy, 1);
    reset = 1; cyc(1); reset = 0;
    bus.wave_in = 0;
    chk("t7 reset busy", bus.busy, 0);
    chk("t7 reset done", bus.done, 0);
    chk("t7 reset m", bus.m_out, 0);
    go(1, 0);
    chk("t7 zero table m", bus.m_out, 0);
    chk("t7 zero table n", bus.n_out, 0);
    chk("t7 busy after start", bus.busy, 1);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
